// File: rtl/alu_exec_stage_pkg.sv
// Shared word size, op and FSM encodings
// for the ALU execute stage.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package alu_exec_stage_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

endpackage

// File: rtl/alu.sv
// Combinational two's complement adder/subtractor
// with signed overflow detection.
module alu #(
  parameter int WIDTH = `WORD_SIZE
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] c,
  output logic             overflow
);

  logic [WIDTH-1:0] bx;

  // SUB is a + ~b + 1; overflow when both addends share
  // a sign that the sum does not.
  always_comb begin
    bx       = mode ? ~b : b;
    c        = a + bx + {{(WIDTH-1){1'b0}}, mode};
    overflow = (a[WIDTH-1] == bx[WIDTH-1])
             && (c[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_exec_stage_reg_file.sv
// Register file: two captured read ports, one
// combinational debug port, one write port.
module alu_exec_stage_reg_file #(
  parameter int WIDTH = `WORD_SIZE,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      rdata_a <= regs[raddr_a];
      rdata_b <= regs[raddr_b];
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_exec_stage.sv
// Four-state execute stage: read, ALU, writeback,
// with sticky overflow and an idle-time load port.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int WIDTH = `WORD_SIZE,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_ovf,
  output logic             ovf_flag,
  input  logic             ovf_clr
);

  logic [1:0]       state;
  logic             op_q;
  logic             mode_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rs1_q;
  logic [AW-1:0]    rs2_q;
  logic [AW-1:0]    wb_rd_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c;
  logic             alu_ovf;
  logic [WIDTH-1:0] res_q;
  logic             ovf_q;
  logic             idle;
  logic             in_wb;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  assign idle     = (state == S_IDLE);
  assign in_wb    = (state == S_WB);
  assign in_ready = idle;

  // Loads only land in IDLE, so they never collide with WB.
  assign we    = in_wb | (idle & ld_en);
  assign waddr = in_wb ? wb_rd_q : ld_addr;
  assign wdata = in_wb ? res_q : ld_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= OP_ADD;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          state <= S_READ;
          op_q  <= in_op;
          rd_q  <= in_rd;
          rs1_q <= in_rs1;
          rs2_q <= in_rs2;
        end
        S_READ:  state <= S_EXEC;
        S_EXEC:  state <= S_WB;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= OP_ADD;
    end else if (state == S_READ) begin
      mode_q <= op_q;
    end
  end

  // Writeback bundle is loaded in EXEC and then held,
  // so the wb_* outputs keep their value between ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      ovf_q   <= 1'b0;
      wb_rd_q <= '0;
    end else if (state == S_EXEC) begin
      res_q   <= c;
      ovf_q   <= alu_ovf;
      wb_rd_q <= rd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flag <= 1'b0;
    end else if (in_wb && ovf_q) begin
      ovf_flag <= 1'b1;
    end else if (ovf_clr) begin
      ovf_flag <= 1'b0;
    end
  end

  assign wb_valid = in_wb;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = res_q;
  assign wb_ovf   = ovf_q;

  alu_exec_stage_reg_file #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re       (state == S_READ),
    .raddr_a  (rs1_q),
    .raddr_b  (rs2_q),
    .rdata_a  (a_q),
    .rdata_b  (b_q),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .mode     (mode_q),
    .c        (c),
    .overflow (alu_ovf)
  );

endmodule
